// File: rtl/fifo_drain_pkg.sv
// Shared types and elaboration-time helpers for the FIFO drain serializer.
package fifo_drain_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of OUT_W-wide slices in one FIFO word.
  function automatic int slices(input int word_w, input int slice_w);
    return word_w / slice_w;
  endfunction

  // Slice-index width; a single-slice word still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_serializer.sv
// Read-side agent for fifo_flops: pops head words and streams them out
// LSB slice first over a valid/ready handshake.
module fifo_drain_serializer
  import fifo_drain_pkg::*;
#(
  parameter int bits  = 32,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pndng,
  input  logic [bits-1:0]  fifo_dout,
  output logic             pop,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_popped
);

  localparam int N     = slices(bits, OUT_W);
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (bits % OUT_W != 0) begin : g_width_check
    $error("fifo_drain_serializer: bits must be a multiple of OUT_W");
  end

  state_t           state_reg, state_next;
  logic [bits-1:0]  shreg_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] words_popped_reg;
  logic             accept;
  logic             load;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic. Holding pop low while reset is asserted keeps the
  // FIFO from advancing past a word the serializer cannot capture.
  always_comb begin
    accept     = out_valid && out_ready;
    load       = rst && en && pndng &&
                 ((state_reg == IDLE) || (accept && out_last));
    state_next = state_reg;
    if (load)
      state_next = SEND;
    else if (state_reg == SEND && accept && out_last)
      state_next = IDLE;
  end

  // Output logic
  always_comb begin
    pop          = load;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b0;
    out_data     = '0;
    words_popped = words_popped_reg;
    if (state_reg == SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = (idx_reg == LAST_IDX);
      out_data  = shreg_reg[OUT_W-1:0];
    end
  end

  // Datapath: a stalled slice leaves shreg/idx untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_reg        <= '0;
      idx_reg          <= '0;
      words_popped_reg <= '0;
    end else if (load) begin
      shreg_reg        <= fifo_dout;
      idx_reg          <= '0;
      words_popped_reg <= words_popped_reg + CNT_W'(1);
    end else if (accept && !out_last) begin
      shreg_reg <= shreg_reg >> OUT_W;
      idx_reg   <= idx_reg + IDX_W'(1);
    end
  end

endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
- Consumer-side (read-end) agent for the fifo_flops interface. It watches pndng, issues pop, and captures the head word from Dout.
- Each captured word is sent LSB-slice-first to a narrower downstream stream with a valid/ready handshake.
- It sits between a fifo_flops instance and a byte-wide sink, for example a UART or bus bridge, and is the counterpart of the push-side producer.

Parameters:
- bits, 32, FIFO word width; must equal the connected fifo_flops width.
- OUT_W, 8, downstream slice width; bits % OUT_W == 0 is required (elaboration-time $error otherwise).
- CNT_W, 16, width of the popped-word counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  drain enable; when 0, no new pops are issued.
- pndng  in  1  FIFO not-empty, from fifo_flops.
- fifo_dout  in  bits  FIFO head word (show-ahead); valid whenever pndng=1.
- pop  out  1  pop strobe to fifo_flops, one cycle per word.
- out_data  out  OUT_W  current slice.
- out_valid  out  1  slice valid.
- out_ready  in  1  downstream accepts the slice when out_valid && out_ready at a rising edge.
- out_last  out  1  marks the final slice of a word.
- busy  out  1  a word is held, i.e. state is SEND.
- words_popped  out  CNT_W  count of pops issued; wraps modulo 2^CNT_W.

Behaviour:
- Constants:
  - N = bits/OUT_W slices per word.
  - idx is a clog2(N)-bit slice index (a 1-bit register tied to 0 when N=1).
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - pop=0, out_valid=0, out_data=0, out_last=0, busy=0, words_popped=0, shift register=0, idx=0.
  - A word held when reset asserts mid-operation is discarded; it is not re-popped.
- States: IDLE, SEND.
- load = en && pndng && (state==IDLE || (state==SEND && out_valid && out_ready && out_last)).
- pop = load. It is combinational from registered state plus the inputs; no other term.
  - pop is never 1 when pndng=0, so the block cannot cause a FIFO underflow.
- On a load edge:
  - shreg <= fifo_dout; idx <= 0; state <= SEND.
  - words_popped <= words_popped+1.
- SEND:
  - out_valid=1, out_data=shreg[OUT_W-1:0], out_last=(idx==N-1), busy=1.
  - Accept edge when not last: shreg <= shreg >> OUT_W; idx <= idx+1.
  - Accept edge when last: if load, reload (zero-bubble back-to-back); otherwise state <= IDLE.
- IDLE: out_valid=0, out_last=0, busy=0, out_data=0.
- Latency and throughput:
  - First slice is valid the cycle after the pop cycle (one-cycle latency from pndng rising with en=1).
  - Sustained rate with out_ready=1 is one word per N cycles, with no idle cycles between words.
- Stall rule: while out_valid && !out_ready, out_data, out_last and idx hold stable.
- en=0 mid-word: the current word completes normally; no further pops; returns to IDLE after the last slice.
- pndng dropping while in SEND has no effect on the held word.
- N=1: every accepted slice is last, and a pop coincides with each acceptance when pndng=1.
- Counter wraps from 2^CNT_W-1 to 0 silently.

Decomposition:
- Package fifo_drain_pkg:
  - state enum typedef state_t {IDLE, SEND}.
  - Constant function slices(bits,OUT_W) and index-width helper.
- Sub-module: none required. The shift register and counter stay inline; the module is one FSM plus a datapath at roughly 150 lines.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, then 1 with pndng=0 -> pop never 1, out_valid=0, words_popped=0.
- Single word: fifo holds 32'hA1B2C3D4, en=1, out_ready=1 -> pop for exactly one cycle; then bytes D4, C3, B2, A1 on consecutive cycles, out_last only on A1; words_popped=1; then IDLE.
- Back-to-back: 3 words pushed (0x04030201, 0x08070605, 0x0C0B0A09), out_ready=1 -> 12 contiguous bytes 01..0C; pop coincides with each out_last acceptance; words_popped=3.
- Backpressure: out_ready toggled 1,0,0,1,... during a word -> out_data stable across stalled cycles; byte order unchanged; no extra pop.
- Enable gating: en drops during byte 2 of word 0x11223344 with a second word pending -> bytes 44, 33, 22, 11 complete; no pop until en=1 again; pndng stays 1.
- Async reset mid-word: rst=0 between clock edges after byte 1 -> outputs and counter are 0 immediately; after release with pndng=1, the next FIFO word starts at byte 0.
